// File: rtl/mmio_pkg.sv
// Shared address map and decode for the MMIO I/O controller.
// MMIO_IRQ_EN adds the MASK register to the decode.
package mmio_pkg;

   localparam logic [15:0] ADDR_MASK = 16'hFFEC;
   localparam logic [15:0] ADDR_SW   = 16'hFFF0;
   localparam logic [15:0] ADDR_BTN  = 16'hFFF4;
   localparam logic [15:0] ADDR_EVT  = 16'hFFF8;
   localparam logic [15:0] ADDR_LED  = 16'hFFFC;

   typedef enum logic [2:0] {
      REG_NONE, REG_MASK, REG_SW, REG_BTN, REG_EVT, REG_LED
   } io_reg_t;

   // Exact-match decode: unaligned offsets fall through to REG_NONE.
   function automatic io_reg_t io_decode(input logic [15:0] addr);
      io_reg_t r;
      case (addr)
         ADDR_SW:   r = REG_SW;
         ADDR_BTN:  r = REG_BTN;
         ADDR_EVT:  r = REG_EVT;
         ADDR_LED:  r = REG_LED;
`ifdef MMIO_IRQ_EN
         ADDR_MASK: r = REG_MASK;
`endif
         default:   r = REG_NONE;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mmio_debounce.sv
// Per-button debouncer: stable follows din_sync only after DEB_CYCLES
// consecutive disagreeing cycles; rise flags the cycle stable goes 0->1.
module mmio_debounce #(
   parameter int DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic din_sync,
   output logic stable,
   output logic rise
);

   localparam int CW = $clog2(DEB_CYCLES);

   logic [CW-1:0] cnt;
   logic          take;

   // cnt tops out at DEB_CYCLES-1 because reaching it always clears it.
   assign take = (din_sync != stable) && (cnt == CW'(DEB_CYCLES - 1));
   assign rise = take & din_sync;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt    <= '0;
         stable <= 1'b0;
      end else if (din_sync == stable) begin
         cnt    <= '0;
      end else if (take) begin
         stable <= din_sync;
         cnt    <= '0;
      end else begin
         cnt    <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped switch/button/LED port with sticky W1C press events.
// Define MMIO_IRQ_EN to add the MASK register and the irq output.
module mmio_io_ctrl
   import mmio_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int NUM_SW     = 10,
   parameter int NUM_BTN    = 2,
   parameter int NUM_LED    = 10,
   parameter int DEB_CYCLES = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   addr,
   input  logic               wr_en,
   input  logic [WIDTH-1:0]   wr_data,
   output logic [WIDTH-1:0]   rd_data,
   output logic               io_hit,
   input  logic [NUM_BTN-1:0] buttons,
   input  logic [NUM_SW-1:0]  switches,
   output logic [NUM_LED-1:0] leds
`ifdef MMIO_IRQ_EN
   ,
   output logic               irq
`endif
);

   logic [NUM_SW-1:0]  sw_meta, sw_sync;
   logic [NUM_BTN-1:0] btn_meta, btn_sync;
   logic [NUM_BTN-1:0] btn_stable, btn_rise;
   logic [NUM_BTN-1:0] evt, evt_clr;
   logic [WIDTH-1:0]   rd_next;
   io_reg_t            reg_sel;
   logic               unused_bits;

   // Only the low half of the address and the low data bits matter.
   assign unused_bits = ^{addr[WIDTH-1:16], wr_data};

   assign reg_sel = io_decode(addr[15:0]);
   assign io_hit  = (reg_sel != REG_NONE);
   assign evt_clr = (wr_en && reg_sel == REG_EVT) ? wr_data[NUM_BTN-1:0] : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sw_meta  <= '0;
         sw_sync  <= '0;
         btn_meta <= '0;
         btn_sync <= '0;
      end else begin
         sw_meta  <= switches;
         sw_sync  <= sw_meta;
         btn_meta <= buttons;
         btn_sync <= btn_meta;
      end
   end

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      mmio_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
         .clk      (clk),
         .rst      (rst),
         .din_sync (btn_sync[i]),
         .stable   (btn_stable[i]),
         .rise     (btn_rise[i])
      );
   end

`ifdef MMIO_IRQ_EN
   logic [NUM_BTN-1:0] mask;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mask <= '0;
         irq  <= 1'b0;
      end else begin
         if (wr_en && reg_sel == REG_MASK) mask <= wr_data[NUM_BTN-1:0];
         irq <= |(evt & mask);
      end
   end
`endif

   always_comb begin
      rd_next = '0;
      case (reg_sel)
         REG_SW:   rd_next[NUM_SW-1:0]  = sw_sync;
         REG_BTN:  rd_next[NUM_BTN-1:0] = btn_stable;
         REG_EVT:  rd_next[NUM_BTN-1:0] = evt;
         REG_LED:  rd_next[NUM_LED-1:0] = leds;
`ifdef MMIO_IRQ_EN
         REG_MASK: rd_next[NUM_BTN-1:0] = mask;
`endif
         default:  ;
      endcase
   end

   // A fresh rise overrides a same-cycle clear so no press is lost.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         evt     <= '0;
         leds    <= '0;
         rd_data <= '0;
      end else begin
         evt     <= (evt & ~evt_clr) | btn_rise;
         if (wr_en && reg_sel == REG_LED) leds <= wr_data[NUM_LED-1:0];
         rd_data <= rd_next;
      end
   end

endmodule
